run_limit_tx: RTL and testbench

- Serial transmitter for the run-limited single-wire link.
- Accepts parallel bytes over a valid/ready handshake and shifts them out MSB-first, one bit per bit-slot.
- Inserts a complementary stuff bit whenever MAX_RUN identical bits have been sent, so the line never shows a run of MAX_RUN+1 identical bits.
- Drives the input of the line's run detector; an all-0 or all-1 run of four on the link is therefore always a fault, never data.

---
 rtl/run_limit_tx.sv | 105 ++++++++++
 tb/tb_run_limit_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_limit_tx.sv
// Run-limited serial transmitter: shifts bytes out MSB-first, one bit per slot,
// and inserts a complementary stuff bit after MAX_RUN identical line bits.
module run_limit_tx #(
    parameter int DIV     = 125000000,
    parameter int DATA_W  = 8,
    parameter int MAX_RUN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              stuff,
    output logic              done,
    output logic              fsm_state
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = $clog2(MAX_RUN + 1);
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic              last_bit;
    logic [RW-1:0]     run_cnt;
    logic [DATA_W-1:0] shift;
    logic [BW-1:0]     bit_idx;
    logic              data_bit;
    logic [RW-1:0]     run_data;

    // Handshake: a word is taken on any clk edge where valid && ready; ready is
    // high exactly while IDLE, so valid during SEND is ignored and data_in is
    // only needed in the accepting cycle.
    assign ready     = (state == IDLE);
    assign busy      = (state == SEND);
    assign fsm_state = state;

    assign tick     = (tick_cnt == TW'(DIV - 1));
    assign data_bit = shift[DATA_W-1];
    assign run_data = (data_bit == last_bit) ? run_cnt + RW'(1) : RW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            state    <= IDLE;
            out      <= 1'b0;
            stuff    <= 1'b0;
            done     <= 1'b0;
            last_bit <= 1'b0;
            run_cnt  <= RW'(1);
            shift    <= '0;
            bit_idx  <= '0;
        end else begin
            done     <= 1'b0;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            case (state)
                IDLE: begin
                    // An idle toggle always differs from the previous slot.
                    if (tick) begin
                        out      <= ~last_bit;
                        stuff    <= 1'b0;
                        last_bit <= ~last_bit;
                        run_cnt  <= RW'(1);
                    end
                    if (valid) begin
                        shift   <= data_in;
                        bit_idx <= BW'(DATA_W);
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (tick) begin
                        if (run_cnt == RW'(MAX_RUN)) begin
                            out      <= ~last_bit;
                            stuff    <= 1'b1;
                            last_bit <= ~last_bit;
                            run_cnt  <= RW'(1);
                        end else begin
                            out      <= data_bit;
                            stuff    <= 1'b0;
                            last_bit <= data_bit;
                            run_cnt  <= run_data;
                            shift    <= {shift[DATA_W-2:0], 1'b0};
                            bit_idx  <= bit_idx - BW'(1);
                            if (bit_idx == BW'(1)) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_limit_tx.sv
// Bench for run_limit_tx: slot-level reference model (bit queue per word),
// directed slot patterns, reset-mid-word and 1000 random words with gaps.
module tb_run_limit_tx;

    localparam int DIV     = 4;
    localparam int DATA_W  = 8;
    localparam int MAX_RUN = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic              valid;
    logic              ready, out, busy, stuff, done, fsm_state;

    always #5 clk = ~clk;

    run_limit_tx #(.DIV(DIV), .DATA_W(DATA_W), .MAX_RUN(MAX_RUN)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
        .ready(ready), .out(out), .busy(busy), .stuff(stuff), .done(done),
        .fsm_state(fsm_state)
    );

    int checks = 0;
    int errors = 0;

    // reference model of the link
    int   m_cyc;
    logic m_last;
    int   m_run;
    logic m_idle;
    logic m_out, m_stuff, m_done, m_tick, m_accepted;
    logic m_bits[$];

    // scoreboard and independent observers
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] rec_word;
    int                rec_n;
    int                act_run;
    logic              act_last;
    logic [1:0]        slot_q[$];
    logic              log_all;
    int                done_cnt;
    int                last_done_cyc;
    int                cyc_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk: predict the edge from the current inputs, then compare at #1.
    task automatic cycle();
        logic              pre_idle;
        logic              emit;
        logic              do_reset;
        logic              v;
        logic [DATA_W-1:0] d;
        do_reset   = reset;
        v          = valid;
        d          = data_in;
        pre_idle   = m_idle;
        m_tick     = 1'b0;
        m_accepted = 1'b0;
        m_done     = 1'b0;
        if (do_reset) begin
            m_cyc   = 0;
            m_last  = 1'b0;
            m_run   = 1;
            m_idle  = 1'b1;
            m_out   = 1'b0;
            m_stuff = 1'b0;
            m_bits.delete();
        end else begin
            m_tick = ((m_cyc % DIV) == DIV - 1);
            m_cyc++;
            if (m_tick) begin
                if (m_idle) begin
                    emit    = ~m_last;
                    m_stuff = 1'b0;
                end else if (m_run == MAX_RUN) begin
                    emit    = ~m_last;
                    m_stuff = 1'b1;
                end else begin
                    emit    = m_bits.pop_front();
                    m_stuff = 1'b0;
                    if (m_bits.size() == 0) begin
                        m_done = 1'b1;
                        m_idle = 1'b1;
                    end
                end
                m_run  = (emit == m_last) ? m_run + 1 : 1;
                m_last = emit;
                m_out  = emit;
            end
            if (pre_idle && v) begin
                for (int i = DATA_W - 1; i >= 0; i--) m_bits.push_back(d[i]);
                m_idle     = 1'b0;
                m_accepted = 1'b1;
                exp_q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        cyc_total++;
        check("out", out, m_out);
        check("stuff", stuff, m_stuff);
        check("done", done, m_done);
        check("ready", ready, m_idle);
        check("busy", busy, !m_idle);
        check("fsm_state", fsm_state, !m_idle);
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc_total;
        end
        if (do_reset) begin
            act_run  = 1;
            act_last = 1'b0;
            rec_n    = 0;
            exp_q.delete();
        end else if (m_tick) begin
            act_run  = (out === act_last) ? act_run + 1 : 1;
            act_last = out;
            check("run_len_ok", act_run <= MAX_RUN, 1);
            if (log_all || !pre_idle) slot_q.push_back({stuff, out});
            if (!pre_idle && stuff === 1'b0) begin
                rec_word = {rec_word[DATA_W-2:0], out};
                rec_n++;
                if (rec_n == DATA_W) begin
                    rec_n = 0;
                    if (exp_q.size() == 0) check("rec_extra", 1, 0);
                    else check("rec_word", rec_word, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (!m_idle && n < max_cyc) begin
            cycle();
            n++;
        end
        if (!m_idle) check("timeout_idle", 0, 1);
    endtask

    task automatic wait_accept(input int max_cyc);
        int n;
        n = 0;
        m_accepted = 1'b0;
        while (!m_accepted && n < max_cyc) begin
            cycle();
            n++;
        end
        if (!m_accepted) check("timeout_accept", 0, 1);
    endtask

    task automatic compare_log(input string tag, input logic [31:0] pat_out,
                               input logic [31:0] pat_stuff, input int n);
        check({tag, "_len"}, slot_q.size(), n);
        for (int i = 0; i < n && i < slot_q.size(); i++)
            check(tag, slot_q[i], {pat_stuff[n-1-i], pat_out[n-1-i]});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int sent;
        int budget;
        int acc_cyc;
        reset     = 1'b1;
        valid     = 1'b0;
        data_in   = '0;
        log_all   = 1'b0;
        rec_word  = '0;
        done_cnt  = 0;
        cyc_total = 0;
        last_done_cyc = 0;
        m_idle    = 1'b1;

        // idle toggling after reset
        do_reset();
        check("rst_out", out, 0);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        slot_q.delete();
        log_all = 1'b1;
        repeat (16) cycle();
        compare_log("idle_slots", 32'b1010, 32'b0000, 4);
        log_all = 1'b0;

        // 0xA5 accepted in the first clk after reset
        do_reset();
        slot_q.delete();
        done_cnt = 0;
        valid    = 1'b1;
        data_in  = 8'hA5;
        cycle();
        valid    = 1'b0;
        wait_idle(200);
        compare_log("a5_slots", 32'b10100101, 32'b0, 8);
        check("a5_done_cnt", done_cnt, 1);
        repeat (6) cycle();

        // 0xFF: two stuff bits, ten slots
        do_reset();
        slot_q.delete();
        done_cnt = 0;
        valid    = 1'b1;
        data_in  = 8'hFF;
        cycle();
        valid    = 1'b0;
        wait_idle(200);
        compare_log("ff_slots", 32'b1110111011, 32'b0001000100, 10);
        check("ff_done_cnt", done_cnt, 1);
        repeat (6) cycle();

        // two 0x00 words back to back with valid held high
        do_reset();
        slot_q.delete();
        done_cnt = 0;
        valid    = 1'b1;
        data_in  = 8'h00;
        wait_accept(10);
        wait_accept(200);
        acc_cyc  = cyc_total;
        check("b2b_gap", acc_cyc - last_done_cyc, 1);
        valid    = 1'b0;
        wait_idle(200);
        compare_log("zz_slots", 32'b001000100010001000100, 32'b001000100010001000100, 21);
        check("zz_done_cnt", done_cnt, 2);
        repeat (6) cycle();

        // reset in slot 4 of 0x0F, then 0x3C from a fresh run count
        do_reset();
        slot_q.delete();
        valid   = 1'b1;
        data_in = 8'h0F;
        cycle();
        valid   = 1'b0;
        budget  = 0;
        while (slot_q.size() < 4 && budget < 100) begin
            cycle();
            budget++;
        end
        reset = 1'b1;
        cycle();
        check("midrst_out", out, 0);
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        reset   = 1'b0;
        slot_q.delete();
        valid   = 1'b1;
        data_in = 8'h3C;
        cycle();
        valid   = 1'b0;
        wait_idle(200);
        compare_log("3c_slots", 32'b0011101100, 32'b0010010000, 10);
        repeat (6) cycle();

        // random words with random valid gaps
        do_reset();
        sent   = 0;
        budget = 0;
        while (sent < 1000 && budget < 80000) begin
            if (!valid && $urandom_range(0, 3) == 0) begin
                valid   = 1'b1;
                data_in = DATA_W'($urandom);
            end
            cycle();
            budget++;
            if (m_accepted) begin
                sent++;
                data_in = DATA_W'($urandom);
                if (sent >= 1000 || $urandom_range(0, 1) == 0) valid = 1'b0;
            end else if (!m_idle && $urandom_range(0, 7) == 0) begin
                valid   = ~valid;
                data_in = DATA_W'($urandom);
            end
        end
        valid = 1'b0;
        check("rand_sent", sent, 1000);
        wait_idle(200);
        repeat (8) cycle();
        check("rand_drained", exp_q.size(), 0);
        check("rand_partial", rec_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
